// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin front end that shares one registered ALU between
// NREQ requesters. Each operation is accepted over a valid/ready handshake,
// its operands are registered onto the ALU inputs, and once the ALU latency
// has elapsed the result is returned to the granted requester over valid/ready.
module alu_arbiter #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 8,
  parameter int SELW    = 4,
  parameter int ALU_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ*SELW-1:0]  req_op,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  rsp_err,
  output logic [WIDTH-1:0]      alu_a,
  output logic [WIDTH-1:0]      alu_b,
  output logic [SELW-1:0]       alu_sel,
  input  logic [WIDTH-1:0]      alu_y,
  output logic                  busy
);

  localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SUMW = PTRW + 1;  // holds rr_ptr + NREQ before wrapping
  localparam int CNTW = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [PTRW-1:0]   rr_ptr;
  logic [PTRW-1:0]   gnt;
  logic [CNTW-1:0]   cnt;

  logic [WIDTH-1:0]  field_a   [NREQ];
  logic [WIDTH-1:0]  field_b   [NREQ];
  logic [SELW-1:0]   field_op  [NREQ];

  logic              win_found;
  logic [PTRW-1:0]   win_idx;
  logic              win_legal;
  logic              accept;
  logic              lat_done;
  logic [SUMW-1:0]   sum;

  // Unpack the flat request buses into per-requester fields.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      field_a[i]  = req_a[i*WIDTH +: WIDTH];
      field_b[i]  = req_b[i*WIDTH +: WIDTH];
      field_op[i] = req_op[i*SELW +: SELW];
    end
  end

  // Round-robin search: first valid requester after rr_ptr, wrapping.
  always_comb begin
    // NOTE: every variable written in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    win_found = 1'b0;
    win_idx   = '0;
    sum       = '0;
    for (int k = 1; k <= NREQ; k++) begin
      sum = {1'b0, rr_ptr} + SUMW'(k);
      if (sum >= SUMW'(NREQ)) sum = sum - SUMW'(NREQ);
      if (!win_found && req_valid[sum[PTRW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = sum[PTRW-1:0];
      end
    end
  end

  // Only select codes with all upper bits clear are real ALU operations.
  assign win_legal = (field_op[win_idx][SELW-1:2] == '0);
  assign lat_done  = (cnt == CNTW'(ALU_LAT));

  // Next-state logic and the combinational accept strobe.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (win_found) begin
          req_ready[win_idx] = 1'b1;
          accept             = 1'b1;
          state_nxt          = win_legal ? EXEC : RESP;
        end
      end
      EXEC: begin
        if (lat_done) state_nxt = RESP;
      end
      RESP: begin
        if (rsp_ready[gnt]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Datapath: operand capture on accept, latency count, result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= PTRW'(NREQ - 1);
      gnt      <= '0;
      cnt      <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_sel  <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            alu_a   <= field_a[win_idx];
            alu_b   <= field_b[win_idx];
            alu_sel <= field_op[win_idx];
            gnt     <= win_idx;
            rr_ptr  <= win_idx;
            cnt     <= '0;
            if (!win_legal) begin
              // Illegal select: the ALU still sees the operands, but the
              // requester gets a zero result flagged as an error.
              rsp_data <= '0;
              rsp_err  <= 1'b1;
            end
          end
        end
        EXEC: begin
          cnt <= cnt + CNTW'(1);
          if (lat_done) begin
            rsp_data <= alu_y;
            rsp_err  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Response valid is steered to the granted requester while in RESP.
  always_comb begin
    rsp_valid = '0;
    if (state == RESP) rsp_valid[gnt] = 1'b1;
  end

  assign busy = (state != IDLE);

endmodule
